// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the
// two-requester shift-add multiplier.
package mult_sched_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_sched_if.sv
// Request/ack and operand bundle between
// the two requesters and mult_sched.
interface mult_sched_if
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic               req0;
  logic               req1;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               ack0;
  logic               ack1;
  logic               grant;
  logic               busy;
  logic [2*WIDTH-1:0] product;

  modport master (
    output req0, req1,
    output a0, b0, a1, b1,
    input  ack0, ack1,
    input  grant, busy, product
  );

  modport slave (
    input  req0, req1,
    input  a0, b0, a1, b1,
    output ack0, ack1,
    output grant, busy, product
  );

endinterface

// File: rtl/mult_step.sv
// One add-and-shift step of the
// unsigned multiplier.
module mult_step
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic               i_bit,
  input  logic [CW-1:0]      i_cnt,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] w_term;

  assign w_term = {{WIDTH{1'b0}}, i_mcand} << i_cnt;
  assign o_acc  = i_bit ? i_acc + w_term : i_acc;

endmodule

// File: rtl/mult_sched.sv
// Round-robin arbiter in front of a
// WIDTH-cycle shift-add multiplier.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_sched_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [CW-1:0]      r_cnt;
  logic               r_grant;
  logic               r_last;
  logic               w_pick;
  logic               w_start;
  logic               w_last_step;

  // On a tie, the requester not served last wins
  always_comb begin
    w_pick = r_grant;
    unique case (1'b1)
      bus.req0 && bus.req1:  w_pick = ~r_last;
      bus.req0 && !bus.req1: w_pick = 1'b0;
      !bus.req0 && bus.req1: w_pick = 1'b1;
      default:               w_pick = r_grant;
    endcase
  end

  assign w_start = (r_state == IDLE)
                && (bus.req0 || bus.req1);

  assign w_last_step = (r_state == STEP)
                    && (r_cnt == CW'(WIDTH - 1));

  mult_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_bit   (r_mplier[r_cnt]),
    .i_cnt   (r_cnt),
    .o_acc   (w_acc_next)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_next = STEP;
      STEP:    if (w_last_step) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_cnt     <= '0;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
    end else if (w_start) begin
      r_mcand  <= w_pick ? bus.a1 : bus.a0;
      r_mplier <= w_pick ? bus.b1 : bus.b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_grant  <= w_pick;
      r_last   <= w_pick;
    end else if (r_state == STEP) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last_step) r_product <= w_acc_next;
    end
  end

  assign bus.ack0    = (r_state == DONE) && !r_grant;
  assign bus.ack1    = (r_state == DONE) && r_grant;
  assign bus.grant   = r_grant;
  assign bus.busy    = (r_state != IDLE);
  assign bus.product = r_product;

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched:
// vector table, corner sequences, random.
module tb_mult_sched;
  import mult_sched_pkg::*;

  localparam int W = WIDTH_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mult_sched_if #(.WIDTH(W)) bus();

  mult_sched #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int errors = 0;

  typedef struct {
    logic         who;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [31:0]  exp;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ack0 && bus.ack1) begin
      errors++;
      $display("FAIL both_acks: ack0=1 ack1=1 required one-hot");
    end
  end

  task automatic set_req(input logic r, input logic v,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
    if (r) begin
      bus.req1 = v; bus.a1 = a; bus.b1 = b;
    end else begin
      bus.req0 = v; bus.a0 = a; bus.b0 = b;
    end
  endtask

  task automatic drop(input logic r);
    if (r) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
  endtask

  task automatic wait_ack(output logic who,
                          output int n,
                          output int nbusy);
    bit got;
    got = 0; who = 1'b0; n = 0; nbusy = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.ack0 || bus.ack1) begin
        got = 1;
        who = bus.ack1;
      end
    end
    if (!got) begin
      tests++;
      errors++;
      $display("FAIL ack_timeout: no ack in 40 cycles, required an ack");
    end
  endtask

  logic        w_who;
  int          n_cyc;
  int          n_busy;
  logic [31:0] held;
  logic        pend[2];
  logic [W-1:0] ma[2];
  logic [W-1:0] mb[2];
  logic        m_last;
  logic        exp_who;

  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0;
    bus.a1 = 0; bus.b1 = 0;

    tbl[0] = '{1'b0, 8'd13,  8'd11,  32'd143};
    tbl[1] = '{1'b0, 8'd0,   8'd200, 32'd0};
    tbl[2] = '{1'b1, 8'd200, 8'd0,   32'd0};
    tbl[3] = '{1'b1, 8'd255, 8'd255, 32'd65025};
    tbl[4] = '{1'b0, 8'd1,   8'd1,   32'd1};
    tbl[5] = '{1'b1, 8'd128, 8'd2,   32'd256};
    tbl[6] = '{1'b0, 8'd255, 8'd1,   32'd255};
    tbl[7] = '{1'b1, 8'd170, 8'd85,  32'd14450};

    #1;
    check("rst_busy",  32'(bus.busy),    32'd0);
    check("rst_ack0",  32'(bus.ack0),    32'd0);
    check("rst_ack1",  32'(bus.ack1),    32'd0);
    check("rst_prod",  32'(bus.product), 32'd0);
    check("rst_grant", 32'(bus.grant),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      set_req(tbl[i].who, 1'b1, tbl[i].a, tbl[i].b);
      wait_ack(w_who, n_cyc, n_busy);
      check("tbl_who",     32'(w_who),       32'(tbl[i].who));
      check("tbl_latency", 32'(n_cyc),       32'(W + 1));
      check("tbl_busy",    32'(n_busy),      32'(W + 1));
      check("tbl_prod",    32'(bus.product), tbl[i].exp);
      check("tbl_grant",   32'(bus.grant),   32'(tbl[i].who));
      drop(tbl[i].who);
      @(posedge clk);
      @(negedge clk);
      check("tbl_idle",  32'(bus.busy), 32'd0);
      check("tbl_once",  32'(bus.ack0 | bus.ack1), 32'd0);
      check("tbl_hold",  32'(bus.product), tbl[i].exp);
    end

    // tie straight out of reset
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 8'd255, 8'd255);
    set_req(1'b1, 1'b1, 8'd2, 8'd3);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(w_who, n_cyc, n_busy);
    check("tie_first_who", 32'(w_who),       32'd0);
    check("tie_first_prd", 32'(bus.product), 32'd65025);
    check("tie_first_gnt", 32'(bus.grant),   32'd0);
    drop(1'b0);
    wait_ack(w_who, n_cyc, n_busy);
    check("tie_second_who", 32'(w_who),       32'd1);
    check("tie_second_prd", 32'(bus.product), 32'd6);
    drop(1'b1);
    @(posedge clk);
    @(negedge clk);

    // round-robin with req1 held for three jobs
    set_req(1'b1, 1'b1, 8'd3, 8'd4);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'd5, 8'd6);
    wait_ack(w_who, n_cyc, n_busy);
    check("rr_1_who", 32'(w_who),       32'd1);
    check("rr_1_prd", 32'(bus.product), 32'd12);
    wait_ack(w_who, n_cyc, n_busy);
    check("rr_2_who", 32'(w_who),       32'd0);
    check("rr_2_prd", 32'(bus.product), 32'd30);
    drop(1'b0);
    wait_ack(w_who, n_cyc, n_busy);
    check("rr_3_who", 32'(w_who),       32'd1);
    check("rr_3_prd", 32'(bus.product), 32'd12);
    drop(1'b1);
    @(posedge clk);
    @(negedge clk);

    // reset in the middle of a job
    set_req(1'b1, 1'b1, 8'd7, 8'd9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(bus.busy),    32'd0);
    check("abort_ack",   32'(bus.ack0 | bus.ack1), 32'd0);
    check("abort_prod",  32'(bus.product), 32'd0);
    check("abort_grant", 32'(bus.grant),   32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_quiet", 32'(bus.ack0 | bus.ack1 | bus.busy), 32'd0);
    end
    rst_n = 1'b1;
    wait_ack(w_who, n_cyc, n_busy);
    check("abort_who", 32'(w_who),       32'd1);
    check("abort_lat", 32'(n_cyc),       32'(W + 1));
    check("abort_prd", 32'(bus.product), 32'd63);
    drop(1'b1);
    @(posedge clk);
    @(negedge clk);

    // operand change after the job started
    set_req(1'b0, 1'b1, 8'd5, 8'd4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.a0 = 8'd9;
    wait_ack(w_who, n_cyc, n_busy);
    check("latch_prd", 32'(bus.product), 32'd20);
    drop(1'b0);
    @(posedge clk);
    @(negedge clk);

    // random traffic against an arbitration/product model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1;
    pend[0] = 0; pend[1] = 0;
    repeat (40) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1;
          ma[r] = W'($urandom);
          mb[r] = W'($urandom);
          set_req(r[0], 1'b1, ma[r], mb[r]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1;
        ma[0] = W'($urandom);
        mb[0] = W'($urandom);
        set_req(1'b0, 1'b1, ma[0], mb[0]);
      end
      exp_who = (pend[0] && pend[1]) ? !m_last : pend[1];
      held = 32'(ma[exp_who]) * 32'(mb[exp_who]);
      wait_ack(w_who, n_cyc, n_busy);
      check("rnd_who",   32'(w_who),       32'(exp_who));
      check("rnd_prod",  32'(bus.product), held);
      check("rnd_grant", 32'(bus.grant),   32'(exp_who));
      m_last = exp_who;
      pend[exp_who] = 0;
      drop(exp_who);
    end
    @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
